// File: rtl/touch_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// touch_led_mode_ctrl
//   Gesture controller between a touch key and its LED. The raw key is
//   synchronised and debounced. Each touch is then classified as a short tap,
//   a double tap or a long press, and that class steps a three-mode LED
//   sequencer (OFF / ON / BLINK).
//
//   Optional feature macro: TOUCH_LED_PWM_EN
//     When defined, ON mode dims the LED with a free-running 4-bit PWM.
//     The duty is PWM_DUTY/16.
//     When undefined, ON mode drives a steady 1.
//
// Ports
//   sys_clk   in   system clock
//   sys_rst   in   synchronous reset, active-high
//   touch_key in   raw touch key, asynchronous, active-low (1 = idle)
//   led_out   out  LED drive, 1 = lit
//   mode      out  current mode: 0 OFF, 1 ON, 2 BLINK
//   short_ev  out  one-cycle pulse, short tap classified
//   dbl_ev    out  one-cycle pulse, double tap classified
//   long_ev   out  one-cycle pulse, long press classified
//
// Gesture FSM state is held in gest_state, and mode in mode_q, for observation.
// -----------------------------------------------------------------------------
module touch_led_mode_ctrl #(
  parameter int DEB_MAX   = 1_000_000,
  parameter int LONG_MAX  = 50_000_000,
  parameter int DBL_MAX   = 12_500_000,
  parameter int BLINK_MAX = 12_500_000
`ifdef TOUCH_LED_PWM_EN
  , parameter logic [3:0] PWM_DUTY = 4'd4
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       touch_key,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       short_ev,
  output logic       dbl_ev,
  output logic       long_ev
);

  localparam int TMR_MAX = (LONG_MAX > DBL_MAX) ? LONG_MAX : DBL_MAX;
  localparam int DW = $clog2(DEB_MAX);
  localparam int TW = $clog2(TMR_MAX);
  localparam int BW = $clog2(BLINK_MAX);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_MAX - 1);
  localparam logic [TW-1:0] LONG_LAST  = TW'(LONG_MAX - 1);
  localparam logic [TW-1:0] DBL_LAST   = TW'(DBL_MAX - 1);
  localparam logic [TW-1:0] TMR_LAST   = TW'(TMR_MAX - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MAX - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HOLD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } gest_t;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_t;

  // ---------------- synchroniser and debounce ----------------
  logic          sync1, key_s;
  logic          key_stable, key_stable_d;
  logic [DW-1:0] deb_cnt;
  logic          press_s, rel_s;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= touch_key;
      key_s <= sync1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_stable   <= 1'b1;
      key_stable_d <= 1'b1;
      deb_cnt      <= '0;
    end else begin
      key_stable_d <= key_stable;
      if (key_s != key_stable) begin
        if (deb_cnt == DEB_LAST) begin
          key_stable <= key_s;
          deb_cnt    <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // The key is active-low, so a press is a falling debounced edge.
  assign press_s = key_stable_d & ~key_stable;
  assign rel_s   = ~key_stable_d & key_stable;

  // ---------------- gesture FSM ----------------
  gest_t         gest_state, gest_next;
  logic [TW-1:0] tmr;
  logic          short_nxt, dbl_nxt, long_nxt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gest_state <= IDLE;
      tmr        <= '0;
      short_ev   <= 1'b0;
      dbl_ev     <= 1'b0;
      long_ev    <= 1'b0;
    end else begin
      gest_state <= gest_next;
      short_ev   <= short_nxt;
      dbl_ev     <= dbl_nxt;
      long_ev    <= long_nxt;
      // The timer restarts on every state change. It saturates so that an
      // arbitrarily long hold never wraps it.
      if (gest_next != gest_state) tmr <= '0;
      else if (tmr != TMR_LAST)    tmr <= tmr + 1'b1;
    end
  end

  always_comb begin
    gest_next = gest_state;
    short_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
    case (gest_state)
      IDLE:   if (press_s) gest_next = PRESS;
      PRESS: begin
        // The long-press threshold wins a tie with a release. A release on
        // that very cycle ends the gesture at once instead of parking in HOLD.
        if (tmr == LONG_LAST) begin
          long_nxt  = 1'b1;
          gest_next = rel_s ? IDLE : HOLD;
        end else if (rel_s) begin
          gest_next = WAIT2;
        end
      end
      HOLD:   if (rel_s) gest_next = IDLE;
      WAIT2: begin
        if (tmr == DBL_LAST) begin
          short_nxt = 1'b1;
          gest_next = IDLE;
        end else if (press_s) begin
          gest_next = PRESS2;
        end
      end
      PRESS2: begin
        if (rel_s) begin
          dbl_nxt   = 1'b1;
          gest_next = IDLE;
        end
      end
      default: gest_next = IDLE;
    endcase
  end

  // ---------------- mode sequencer and LED ----------------
  mode_t         mode_q, mode_next;
  logic [BW-1:0] blk_cnt, blk_next;
  logic          led_next;

`ifdef TOUCH_LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + 1'b1;
  end
`endif

  always_comb begin
    mode_next = mode_q;
    if (long_ev) begin
      mode_next = MODE_OFF;
    end else if (short_ev) begin
      mode_next = (mode_q == MODE_OFF) ? MODE_ON : MODE_OFF;
    end else if (dbl_ev) begin
      mode_next = (mode_q == MODE_BLINK) ? MODE_ON : MODE_BLINK;
    end
  end

  always_comb begin
    led_next = 1'b0;
    blk_next = '0;
    case (mode_next)
`ifdef TOUCH_LED_PWM_EN
      MODE_ON: led_next = (pwm_cnt < PWM_DUTY);
`else
      MODE_ON: led_next = 1'b1;
`endif
      MODE_BLINK: begin
        if (mode_q != MODE_BLINK) begin
          led_next = 1'b1;             // blinking always starts lit
        end else if (blk_cnt == BLINK_LAST) begin
          led_next = ~led_out;
        end else begin
          led_next = led_out;
          blk_next = blk_cnt + 1'b1;
        end
      end
      default: led_next = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q  <= MODE_OFF;
      led_out <= 1'b0;
      blk_cnt <= '0;
    end else begin
      mode_q  <= mode_next;
      led_out <= led_next;
      blk_cnt <= blk_next;
    end
  end

  assign mode = mode_q;

endmodule
